dmem_block_ctrl: RTL



---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_block_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory block controller: word/block widths, FSM state
// encoding and the helpers that move words in and out of a 64-bit block.
package dmem_pkg;

   localparam int WORD_SIZE  = 16;
   localparam int BLOCK_SIZE = 64;

   typedef logic [WORD_SIZE-1:0]  word_t;
   typedef logic [BLOCK_SIZE-1:0] block_t;

   typedef enum logic [2:0] {
      IDLE,
      CPU_RD,
      CPU_WR,
      DMA_GNT,
      DMA_WR
   } dmem_state_t;

   // Word 0 sits in the most significant slot of the block.
   function automatic block_t pack_block(input word_t w0, input word_t w1,
                                         input word_t w2, input word_t w3);
      return {w0, w1, w2, w3};
   endfunction

   function automatic word_t block_word(input block_t b, input logic [1:0] idx);
      word_t w;
      case (idx)
         2'd0:    w = b[63:48];
         2'd1:    w = b[47:32];
         2'd2:    w = b[31:16];
         default: w = b[15:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Backing word store: MEM_DEPTH x 16 bits, one aligned 4-word block write port
// (synchronous) and one aligned 4-word block read port (combinational).
module dmem_array
   import dmem_pkg::*;
#(
   parameter int MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        we,
   input  logic [15:0] waddr,
   input  block_t      wdata,
   input  logic [15:0] raddr,
   output block_t      rdata
);

   localparam int AW = $clog2(MEM_DEPTH);

   word_t         mem [MEM_DEPTH];
   logic [AW-1:0] wbase;
   logic [AW-1:0] rbase;

   // Addresses wrap modulo the depth and are forced onto a 4-word boundary.
   assign wbase = AW'(waddr & ~16'h0003);
   assign rbase = AW'(raddr & ~16'h0003);

   // NOTE: the store has no reset so it maps onto RAM and keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wbase]           <= block_word(wdata, 2'd0);
         mem[wbase | AW'(1)]  <= block_word(wdata, 2'd1);
         mem[wbase | AW'(2)]  <= block_word(wdata, 2'd2);
         mem[wbase | AW'(3)]  <= block_word(wdata, 2'd3);
      end
   end

   assign rdata = pack_block(mem[rbase], mem[rbase | AW'(1)],
                             mem[rbase | AW'(2)], mem[rbase | AW'(3)]);

endmodule

// File: rtl/dmem_block_ctrl.sv
// Block-oriented data-memory controller with fixed latency and BR/BG DMA arbitration.
// Optional access statistics are built when DMEM_ACCESS_STATS_EN is defined.
module dmem_block_ctrl
   import dmem_pkg::*;
#(
   parameter int MEM_LATENCY = 4,
   parameter int MEM_DEPTH   = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  d_readM,
   input  logic                  d_writeM,
   input  logic [15:0]           d_address,
   input  logic [BLOCK_SIZE-1:0] d_data_in,
   output logic [BLOCK_SIZE-1:0] d_data_out,
   output logic                  d_ready,
   input  logic                  BR,
   output logic                  BG,
   input  logic                  dma_write,
   input  logic [15:0]           dma_address,
   input  logic [BLOCK_SIZE-1:0] dma_data,
   output logic                  dma_ack,
   output logic [15:0]           rd_cnt,
   output logic [15:0]           wr_cnt,
   output logic [15:0]           dma_cnt
);

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

   dmem_state_t state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        br_q;
   logic        cpu_load, dma_load;
   logic        done, commit;
   logic [15:0] addr_q;
   block_t      data_q;
   block_t      rd_block;

   assign done    = (cnt == 4'd0);
   assign commit  = done && (state == CPU_WR || state == DMA_WR);
   assign d_ready = done && (state == CPU_RD || state == CPU_WR);
   assign dma_ack = done && (state == DMA_WR);
   assign BG      = (state == DMA_GNT) || (state == DMA_WR);
   assign d_data_out = (done && state == CPU_RD) ? rd_block : '0;

   // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cpu_load  = 1'b0;
      dma_load  = 1'b0;
      case (state)
         IDLE: begin
            // A BR that was already high beats the cache; a BR rising with a cache request loses.
            if (BR && (br_q || !(d_readM || d_writeM))) begin
               state_nxt = DMA_GNT;
            end else if (d_writeM) begin
               state_nxt = CPU_WR;
               cnt_nxt   = LAT_LOAD;
               cpu_load  = 1'b1;
            end else if (d_readM) begin
               state_nxt = CPU_RD;
               cnt_nxt   = LAT_LOAD;
               cpu_load  = 1'b1;
            end
         end
         CPU_RD, CPU_WR: begin
            if (done) state_nxt = IDLE;
            else      cnt_nxt   = cnt - 4'd1;
         end
         DMA_GNT: begin
            if (dma_write) begin
               state_nxt = DMA_WR;
               cnt_nxt   = LAT_LOAD;
               dma_load  = 1'b1;
            end else if (!BR) begin
               state_nxt = IDLE;
            end
         end
         DMA_WR: begin
            if (done) state_nxt = DMA_GNT;
            else      cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         br_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         br_q  <= BR;
      end
   end

   always_ff @(posedge clk) begin
      if (cpu_load) begin
         addr_q <= d_address;
         data_q <= d_data_in;
      end else if (dma_load) begin
         addr_q <= dma_address;
         data_q <= dma_data;
      end
   end

   // A reset on the completing edge must not let the pending write through.
   dmem_array #(.MEM_DEPTH(MEM_DEPTH)) u_array (
      .clk   (clk),
      .we    (commit && !reset),
      .waddr (addr_q),
      .wdata (data_q),
      .raddr (addr_q),
      .rdata (rd_block)
   );

`ifdef DMEM_ACCESS_STATS_EN
   logic [15:0] rd_q, wr_q, dma_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q  <= 16'h0000;
         wr_q  <= 16'h0000;
         dma_q <= 16'h0000;
      end else begin
         if (d_ready && state == CPU_RD && rd_q != 16'hFFFF) rd_q  <= rd_q + 16'd1;
         if (d_ready && state == CPU_WR && wr_q != 16'hFFFF) wr_q  <= wr_q + 16'd1;
         if (dma_ack && dma_q != 16'hFFFF)                    dma_q <= dma_q + 16'd1;
      end
   end

   assign rd_cnt  = rd_q;
   assign wr_cnt  = wr_q;
   assign dma_cnt = dma_q;
`else
   assign rd_cnt  = 16'h0000;
   assign wr_cnt  = 16'h0000;
   assign dma_cnt = 16'h0000;
`endif

endmodule
